// File: rtl/mem_bus_decoder.sv
// Data-memory bus decoder: maps one load/store at a time onto four windowed slave regions,
// applies per-region wait states and returns a registered ready/error handshake.
module mem_bus_decoder #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE0      = 32'h7FFF_EEFC,
  parameter logic [ADDR_WIDTH-1:0] LAST0      = 32'h7FFF_FFFF,
  parameter int unsigned           WAIT0      = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE1      = 32'h1001_002C,
  parameter logic [ADDR_WIDTH-1:0] LAST1      = 32'h1001_003F,
  parameter int unsigned           WAIT1      = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE2      = 32'h1001_0024,
  parameter logic [ADDR_WIDTH-1:0] LAST2      = 32'h1001_002B,
  parameter int unsigned           WAIT2      = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE3      = 32'h0040_0000,
  parameter logic [ADDR_WIDTH-1:0] LAST3      = 32'h0040_0FFF,
  parameter int unsigned           WAIT3      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    cpu_ready,
  output logic                    cpu_err,
  output logic [3:0]              slv_sel,
  output logic [1:0]              slv_idx,
  output logic                    slv_re,
  output logic                    slv_we,
  output logic [ADDR_WIDTH-1:0]   slv_addr,
  output logic [DATA_WIDTH-1:0]   slv_wdata,
  input  logic [4*DATA_WIDTH-1:0] slv_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone, StErr} state_e;

  logic [ADDR_WIDTH-1:0] base  [4];
  logic [ADDR_WIDTH-1:0] last  [4];
  logic [7:0]            waits [4];
  logic [DATA_WIDTH-1:0] rd_slice [4];

  assign base[0]  = BASE0;
  assign base[1]  = BASE1;
  assign base[2]  = BASE2;
  assign base[3]  = BASE3;
  assign last[0]  = LAST0;
  assign last[1]  = LAST1;
  assign last[2]  = LAST2;
  assign last[3]  = LAST3;
  assign waits[0] = 8'(WAIT0);
  assign waits[1] = 8'(WAIT1);
  assign waits[2] = 8'(WAIT2);
  assign waits[3] = 8'(WAIT3);

  for (genvar g = 0; g < 4; g++) begin : g_slice
    assign rd_slice[g] = slv_rdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [3:0]            sel_q, sel_d;
  logic [1:0]            idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  we_q, we_d;

  logic                  hit;
  logic [1:0]            hit_idx;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if ((cpu_addr >= base[i]) && (cpu_addr <= last[i])) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          we_d = cpu_we;
          if (hit) begin
            cnt_d   = waits[hit_idx];
            sel_d   = 4'b0001 << hit_idx;
            idx_d   = hit_idx;
            addr_d  = cpu_addr - base[hit_idx];
            wdata_d = cpu_wdata;
            state_d = StAccess;
          end else begin
            state_d = StErr;
          end
        end
      end
      StAccess: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          rdata_d = we_q ? '0 : rd_slice[idx_q];
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
    end
  end

  // Strobes are gated by state so DONE/ERR never drive a slave.
  always_comb begin
    slv_sel   = (state_q == StAccess) ? sel_q : 4'b0000;
    slv_idx   = idx_q;
    slv_addr  = addr_q;
    slv_wdata = wdata_q;
    slv_re    = (state_q == StAccess) && !we_q;
    slv_we    = (state_q == StAccess) && we_q && (cnt_q == 8'd0);
    cpu_ready = (state_q == StDone) || (state_q == StErr);
    cpu_err   = (state_q == StErr);
    cpu_rdata = (state_q == StDone) ? rdata_q : '0;
  end

endmodule
